// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder/subtractor: parametrised widths, round-to-nearest-even,
// special values, flush-to-zero, iterative one-bit-per-cycle normalisation.
module fp_add_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int unsigned W  = EXP_W + MAN_W + 1;
    localparam int unsigned SW = MAN_W + 4;  // hidden + mantissa + guard/round/sticky
    localparam int unsigned EW = EXP_W + 1;  // spare bit catches exponent overflow
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic          sign_q, sign_d, eff_sub_q, eff_sub_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [SW-1:0] siga_q, siga_d, sigb_q, sigb_d;
    logic [SW:0]   sum_q, sum_d;
    logic [W-1:0]  result_q, result_d;
    logic [3:0]    flags_q, flags_d;

    // Operand unpack; opb_q already carries the effective (op_sub-adjusted) sign.
    logic                   sa, sb, za, zb, infa, infb, nana, nanb, a_big, lost;
    logic [EXP_W-1:0]       ea, eb, e_big, e_small, shamt;
    logic [MAN_W-1:0]       ma, mb;
    logic [EXP_W+MAN_W-1:0] key_a, key_b;
    logic [SW-1:0]          sig_a, sig_b, sig_big, sig_small, sig_shift, lost_mask;

    assign {sa, ea, ma} = opa_q;
    assign {sb, eb, mb} = opb_q;
    assign za    = (ea == '0);
    assign zb    = (eb == '0);
    assign infa  = (ea == EXP_MAX) && (ma == '0);
    assign infb  = (eb == EXP_MAX) && (mb == '0);
    assign nana  = (ea == EXP_MAX) && (ma != '0);
    assign nanb  = (eb == EXP_MAX) && (mb != '0);
    assign key_a = {ea, za ? {MAN_W{1'b0}} : ma};
    assign key_b = {eb, zb ? {MAN_W{1'b0}} : mb};
    assign sig_a = za ? {SW{1'b0}} : {1'b1, ma, 3'b000};
    assign sig_b = zb ? {SW{1'b0}} : {1'b1, mb, 3'b000};

    assign a_big     = (key_a >= key_b);
    assign e_big     = a_big ? ea : eb;
    assign e_small   = a_big ? eb : ea;
    assign sig_big   = a_big ? sig_a : sig_b;
    assign sig_small = a_big ? sig_b : sig_a;
    assign shamt     = e_big - e_small;
    // Oversized shifts give zero / full mask, so sticky collapses to (small != 0).
    assign sig_shift = sig_small >> shamt;
    assign lost_mask = ~({SW{1'b1}} << shamt);
    assign lost      = |(sig_small & lost_mask);

    // Rounding on the normalised sum: [SW-1] hidden, [3] lsb, [2:0] guard/round/sticky.
    logic             round_up;
    logic [MAN_W+1:0] rnd;
    logic [EW-1:0]    exp_rnd;
    logic [MAN_W-1:0] man_rnd;

    assign round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    assign rnd      = {1'b0, sum_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    assign exp_rnd  = rnd[MAN_W+1] ? exp_q + EW'(1) : exp_q;
    assign man_rnd  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        siga_d    = siga_q;
        sigb_d    = sigb_q;
        sum_d     = sum_q;
        result_d  = result_q;
        flags_d   = flags_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = {b[W-1] ^ op_sub, b[W-2:0]};
                    state_d = StAlign;
                end
            end
            StAlign: begin
                state_d = StDone;
                if (nana || nanb || (infa && infb && (sa != sb))) begin
                    result_d = QNAN;
                    flags_d  = 4'b1000;
                end else if (infa) begin
                    result_d = {sa, EXP_MAX, {MAN_W{1'b0}}};
                    flags_d  = 4'b0000;
                end else if (infb) begin
                    result_d = {sb, EXP_MAX, {MAN_W{1'b0}}};
                    flags_d  = 4'b0000;
                end else if (za && zb) begin
                    result_d = {sa & sb, {(W-1){1'b0}}};
                    flags_d  = 4'b0001;
                end else if ((sa != sb) && (key_a == key_b)) begin
                    result_d = '0;
                    flags_d  = 4'b0001;
                end else begin
                    sign_d    = a_big ? sa : sb;
                    eff_sub_d = sa ^ sb;
                    exp_d     = {1'b0, e_big};
                    siga_d    = sig_big;
                    sigb_d    = sig_shift | {{(SW-1){1'b0}}, lost};
                    state_d   = StAdd;
                end
            end
            StAdd: begin
                sum_d   = eff_sub_q ? ({1'b0, siga_q} - {1'b0, sigb_q})
                                    : ({1'b0, siga_q} + {1'b0, sigb_q});
                state_d = StNorm;
            end
            StNorm: begin
                if (sum_q[SW]) begin
                    sum_d   = {1'b0, sum_q[SW:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + EW'(1);
                    state_d = StRound;
                end else if (sum_q[SW-1]) begin
                    state_d = StRound;
                end else if (exp_q == EW'(1)) begin
                    // Another left shift would need exponent 0: flush to signed zero.
                    result_d = {sign_q, {(W-1){1'b0}}};
                    flags_d  = 4'b0011;
                    state_d  = StDone;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - EW'(1);
                    if (sum_q[SW-2]) begin
                        state_d = StRound;
                    end
                end
            end
            StRound: begin
                if (exp_rnd >= {1'b0, EXP_MAX}) begin
                    result_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
                    flags_d  = 4'b0100;
                end else begin
                    result_d = {sign_q, exp_rnd[EXP_W-1:0], man_rnd};
                    flags_d  = 4'b0000;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            opa_q     <= '0;
            opb_q     <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= '0;
            siga_q    <= '0;
            sigb_q    <= '0;
            sum_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            exp_q     <= exp_d;
            siga_q    <= siga_d;
            sigb_q    <= sigb_d;
            sum_q     <= sum_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: single precision plus a half-precision instance,
// with an expected-result queue checked on each done pulse.
module tb_fp_add_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, op_sub, busy, done;
    logic [31:0] a, b, result;
    logic [3:0]  flags;
    logic        s_start, s_op_sub, s_busy, s_done;
    logic [15:0] s_a, s_b, s_result;
    logic [3:0]  s_flags;

    fp_add_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    fp_add_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .start(s_start), .op_sub(s_op_sub), .a(s_a), .b(s_b),
        .busy(s_busy), .done(s_done), .result(s_result), .flags(s_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int unsigned lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic sub,
                         input logic [31:0] x, input logic [31:0] y);
        if (sel) begin
            s_start = st; s_op_sub = sub; s_a = x[15:0]; s_b = y[15:0];
            start = 1'b0;
        end else begin
            start = st; op_sub = sub; a = x; b = y;
            s_start = 1'b0;
        end
    endtask

    // Launch one operation, scramble inputs while busy, then check it on done.
    task automatic run(input string tag, input bit sel, input logic sub,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eres, input logic [3:0] eflg,
                       input int unsigned elat, input bit poke);
        exp_t        e;
        int unsigned cyc;
        bit          got;
        logic [31:0] r1, r2, r3;
        e.res = eres; e.flg = eflg; e.lat = elat;
        sb_q.push_back(e);
        @(negedge clk);
        drive(sel, 1'b1, sub, x, y);
        @(posedge clk);
        cyc = 1; got = 0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            r1 = $urandom; r2 = $urandom; r3 = $urandom;
            drive(sel, poke && (cyc == 1), r1[0], r2, r3);
            if (sel ? s_done : done) got = 1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        e = sb_q.pop_front();
        chk({tag, "/done_seen"}, 32'(got), 32'd1);
        chk({tag, "/result"}, sel ? {16'h0, s_result} : result, e.res);
        chk({tag, "/flags"}, 32'(sel ? s_flags : flags), 32'(e.flg));
        chk({tag, "/latency"}, cyc, e.lat);
        chk({tag, "/busy_at_done"}, 32'(sel ? s_busy : busy), 32'd1);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
    endtask

    initial begin
        int unsigned extra;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_op_sub = 1'b0; s_a = '0; s_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/result", result, 32'h0);
        chk("reset/flags", 32'(flags), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run("one_plus_one", 0, 0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'h0, 5, 0);
        run("one_minus_0p75", 0, 1, 32'h3F800000, 32'h3F400000, 32'h3E800000, 4'h0, 6, 0);
        run("exact_zero", 0, 1, 32'h40490FDB, 32'h40490FDB, 32'h00000000, 4'h1, 2, 0);
        run("neg_zero", 0, 0, 32'h80000000, 32'h80000000, 32'h80000000, 4'h1, 2, 0);
        run("rne_tie_even", 0, 0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'h0, 5, 0);
        run("rne_above", 0, 0, 32'h3F800000, 32'h33800001, 32'h3F800001, 4'h0, 5, 0);
        run("rne_tie_odd", 0, 0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'h0, 5, 0);
        run("overflow", 0, 0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'h4, 5, 0);
        run("inf_minus_inf", 0, 1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h8, 2, 0);
        run("nan_in", 0, 0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h8, 2, 0);
        run("neg_inf", 0, 0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'h0, 2, 0);
        run("long_norm", 0, 1, 32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 4'h0, 28, 0);
        run("underflow", 0, 1, 32'h00C00000, 32'h00800000, 32'h00000000, 4'h3, 4, 0);
        run("neg_result", 0, 1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'h0, 5, 0);
        run("plus_zero", 0, 0, 32'h40490FDB, 32'h00000000, 32'h40490FDB, 4'h0, 5, 0);

        // A start pulsed while busy must not produce a second done.
        run("busy_start", 0, 0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'h0, 5, 1);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("busy_start/extra_done", extra, 32'd0);

        // Reset in the middle of a long normalisation.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h3F800000, 32'h3F7FFFFF);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("midnorm/busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midnorm/busy", 32'(busy), 32'd0);
        chk("midnorm/done", 32'(done), 32'd0);
        chk("midnorm/result", result, 32'h0);
        chk("midnorm/flags", 32'(flags), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("midnorm/no_done", extra, 32'd0);
        run("after_reset", 0, 0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'h0, 5, 0);

        run("h_one_plus_one", 1, 0, 32'h3C00, 32'h3C00, 32'h4000, 4'h0, 5, 0);
        run("h_one_minus_0p75", 1, 1, 32'h3C00, 32'h3A00, 32'h3400, 4'h0, 6, 0);
        run("h_overflow", 1, 0, 32'h7BFF, 32'h7BFF, 32'h7C00, 4'h4, 5, 0);
        run("h_inf_minus_inf", 1, 1, 32'h7C00, 32'h7C00, 32'h7E00, 4'h8, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
